// File: rtl/bar_ctrl.sv
// Frame-synchronous border / warning-bar controller: picks bar visibility and
// border/bar colours once per frame for warning blink, line-clear flash and game over.
module bar_ctrl #(
   parameter int unsigned BAR_Y        = 181,
   parameter int unsigned BLINK_FRAMES = 15,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [10:0] stack_top_y,
   input  logic        game_over,
   input  logic        clear_req,
   output logic        clear_ack,
   output logic        bar_on,
   output logic [11:0] bar_color,
   output logic [11:0] border_color
);

   localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic [10:0]   BAR_Y_W    = 11'(BAR_Y);

   localparam logic [11:0] RED    = 12'hF00;
   localparam logic [11:0] WHITE  = 12'hFFF;
   localparam logic [11:0] YELLOW = 12'hFF0;

   typedef enum logic [1:0] {IDLE, WARN, CLEAR, OVER} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
   logic [FW-1:0]   flashCnt_q, flashCnt_d;
   logic            barOn_q, barOn_d;
   logic [11:0]     barColor_q, barColor_d;
   logic [11:0]     border_q, border_d;
   logic            ack_q, ack_d;
   logic            danger;

   assign danger = (stack_top_y <= BAR_Y_W);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         blinkCnt_q <= '0;
         flashCnt_q <= '0;
         barOn_q    <= 1'b0;
         barColor_q <= RED;
         border_q   <= WHITE;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         blinkCnt_q <= blinkCnt_d;
         flashCnt_q <= flashCnt_d;
         barOn_q    <= barOn_d;
         barColor_q <= barColor_d;
         border_q   <= border_d;
         ack_q      <= ack_d;
      end
   end

   // Game over beats a pending flash, which beats the danger warning.
   always_comb begin
      state_d = state_q;
      if (frame_tick) begin
         unique case (state_q)
            IDLE, WARN: begin
               if (game_over)      state_d = OVER;
               else if (clear_req) state_d = CLEAR;
               else if (danger)    state_d = WARN;
               else                state_d = IDLE;
            end
            CLEAR: begin
               if (game_over)                    state_d = OVER;
               else if (flashCnt_q == FLASH_LAST) state_d = IDLE;
               else                              state_d = CLEAR;
            end
            OVER: begin
               if (!game_over) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are decided by the destination state; any exit from CLEAR releases the requester.
   always_comb begin
      blinkCnt_d = blinkCnt_q;
      flashCnt_d = flashCnt_q;
      barOn_d    = barOn_q;
      barColor_d = barColor_q;
      border_d   = border_q;
      ack_d      = 1'b0;
      if (frame_tick) begin
         ack_d      = (state_q == CLEAR) && (state_d != CLEAR);
         barColor_d = RED;
         unique case (state_d)
            IDLE: begin
               barOn_d    = 1'b0;
               border_d   = WHITE;
               blinkCnt_d = '0;
               flashCnt_d = '0;
            end
            WARN: begin
               border_d = WHITE;
               if (state_q != WARN) begin
                  barOn_d    = 1'b1;
                  blinkCnt_d = '0;
               end else if (blinkCnt_q == BLINK_LAST) begin
                  barOn_d    = ~barOn_q;
                  blinkCnt_d = '0;
               end else begin
                  blinkCnt_d = blinkCnt_q + 1'b1;
               end
            end
            CLEAR: begin
               barOn_d = 1'b0;
               if (state_q != CLEAR) begin
                  flashCnt_d = '0;
                  border_d   = YELLOW;
               end else begin
                  flashCnt_d = flashCnt_q + 1'b1;
                  border_d   = (border_q == YELLOW) ? WHITE : YELLOW;
               end
            end
            OVER: begin
               barOn_d  = 1'b1;
               border_d = RED;
            end
            default: ;
         endcase
      end
   end

   assign clear_ack    = ack_q;
   assign bar_on       = barOn_q;
   assign bar_color    = barColor_q;
   assign border_color = border_q;

endmodule

// File: tb/tb_bar_ctrl.sv
// Scoreboard bench for bar_ctrl: stimulus pushes hand-computed frame outputs,
// a monitor pops and compares them on the cycle after each tick or reset.
module tb_bar_ctrl;

   localparam logic [11:0] RED    = 12'hF00;
   localparam logic [11:0] WHITE  = 12'hFFF;
   localparam logic [11:0] YELLOW = 12'hFF0;

   typedef struct {
      logic        barOn;
      logic [11:0] barColor;
      logic [11:0] border;
      logic        ack;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frameTick = 1'b0;
   logic [10:0] stackTopY = 11'd400;
   logic        gameOver = 1'b0;
   logic        clearReq = 1'b0;
   logic        clearAck;
   logic        barOn;
   logic [11:0] barColor;
   logic [11:0] borderColor;

   exp_t  expQ[$];
   string nameQ[$];
   int    testsRun = 0;
   int    testsFailed = 0;
   logic  outValid = 1'b0;
   logic  armed = 1'b0;

   bar_ctrl #(.BAR_Y(181), .BLINK_FRAMES(15), .FLASH_FRAMES(8)) dut (
      .clk(clk),
      .reset(reset),
      .frame_tick(frameTick),
      .stack_top_y(stackTopY),
      .game_over(gameOver),
      .clear_req(clearReq),
      .clear_ack(clearAck),
      .bar_on(barOn),
      .bar_color(barColor),
      .border_color(borderColor)
   );

   always #5 clk = ~clk;

   // A registered response is due on the cycle after every tick or reset pulse.
   always @(posedge clk) begin
      outValid <= reset || frameTick;
      armed    <= armed || reset;
   end

   task automatic checkOutput();
      exp_t  e;
      string n;
      testsRun++;
      if (expQ.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL unexpected: DUT output with no expectation queued (bar_on=%0b border=%h ack=%0b)",
                  barOn, borderColor, clearAck);
      end else begin
         e = expQ.pop_front();
         n = nameQ.pop_front();
         if (barOn !== e.barOn || barColor !== e.barColor ||
             borderColor !== e.border || clearAck !== e.ack) begin
            testsFailed++;
            $display("[TB] FAIL %s: got bar_on=%0b bar_color=%h border=%h ack=%0b, want bar_on=%0b bar_color=%h border=%h ack=%0b",
                     n, barOn, barColor, borderColor, clearAck, e.barOn, e.barColor, e.border, e.ack);
         end
      end
   endtask

   // Between responses the ack must stay low.
   always @(negedge clk) begin
      if (outValid) begin
         checkOutput();
      end else if (armed) begin
         testsRun++;
         if (clearAck !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL strayAck: got clear_ack=%0b, want 0", clearAck);
         end
      end
   end

   task automatic pushExp(input logic eBarOn, input logic [11:0] eBorder,
                          input logic eAck, input string name);
      exp_t e;
      e.barOn    = eBarOn;
      e.barColor = RED;
      e.border   = eBorder;
      e.ack      = eAck;
      expQ.push_back(e);
      nameQ.push_back(name);
   endtask

   task automatic applyStimulus(input logic go, input logic req, input logic [10:0] y,
                                input logic eBarOn, input logic [11:0] eBorder,
                                input logic eAck, input string name);
      @(posedge clk);
      #1;
      gameOver  = go;
      clearReq  = req;
      stackTopY = y;
      frameTick = 1'b1;
      pushExp(eBarOn, eBorder, eAck, name);
      @(posedge clk);
      #1;
      frameTick = 1'b0;
   endtask

   task automatic doReset(input logic withTick, input string name);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      frameTick = withTick;
      pushExp(1'b0, WHITE, 1'b0, name);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      frameTick = 1'b0;
   endtask

   initial begin
      #1_000_000;
      testsFailed++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      doReset(1'b0, "reset");

      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "idleQuiet");

      // Entry frame plus 14 more on, 15 off, then on again.
      for (int i = 1; i <= 31; i++)
         applyStimulus(1'b0, 1'b0, 11'd181, (i <= 15) || (i == 31), WHITE, 1'b0, "warnBlink");
      applyStimulus(1'b0, 1'b0, 11'd182, 1'b0, WHITE, 1'b0, "warnExit");

      // Flash: entry plus 8 ticks, ack after the last.
      for (int i = 1; i <= 9; i++)
         applyStimulus(1'b0, 1'b1, 11'd400, 1'b0,
                       ((i % 2 == 1) && (i != 9)) ? YELLOW : WHITE, i == 9, "clearFlash");
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "clearDone");
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "clearIdle");

      applyStimulus(1'b0, 1'b1, 11'd400, 1'b0, YELLOW, 1'b0, "abortEntry");
      applyStimulus(1'b0, 1'b1, 11'd400, 1'b0, WHITE, 1'b0, "abortTick2");
      applyStimulus(1'b1, 1'b1, 11'd400, 1'b1, RED, 1'b1, "abortOver");
      applyStimulus(1'b1, 1'b0, 11'd400, 1'b1, RED, 1'b0, "overHold");
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "overExit");

      applyStimulus(1'b1, 1'b1, 11'd100, 1'b1, RED, 1'b0, "priorityOver");
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "priorityExit");

      applyStimulus(1'b0, 1'b0, 11'd100, 1'b1, WHITE, 1'b0, "midWarn1");
      applyStimulus(1'b0, 1'b0, 11'd100, 1'b1, WHITE, 1'b0, "midWarn2");
      doReset(1'b1, "resetWarn");
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "afterResetWarn");

      applyStimulus(1'b0, 1'b1, 11'd400, 1'b0, YELLOW, 1'b0, "midClear1");
      applyStimulus(1'b0, 1'b1, 11'd400, 1'b0, WHITE, 1'b0, "midClear2");
      doReset(1'b1, "resetClear");
      clearReq = 1'b0;
      applyStimulus(1'b0, 1'b0, 11'd400, 1'b0, WHITE, 1'b0, "afterResetClear");

      repeat (3) @(posedge clk);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d expectations left, want 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/bar_ctrl.md
# bar_ctrl

Frame-synchronous controller for the playfield border and warning-bar pixel source. Decides per frame whether the warning bar (rows 181–182) is shown and which colours the border and bar use. Sequences three effects: warning blink, line-clear border flash with a req/ack handshake, and game-over display. Sits between game logic and the bar/border pixel source. All outputs are registered and change only on frame boundaries, so colours are stable for the whole active-video period.

## Interface
- `BAR_Y`, 181 — pixel row of the warning bar top; stack at or above this row means danger.
- `BLINK_FRAMES`, 15 — frames per bar on/off phase in WARN; legal range ≥1.
- `FLASH_FRAMES`, 8 — frames spent in CLEAR; legal range ≥1.

- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse once per frame, at start of vertical blanking.
- `stack_top_y`  in  11  pixel y of the highest occupied cell's top edge.
- `game_over`  in  1  level; high while the game is lost.
- `clear_req`  in  1  level; line-clear flash request, held until `clear_ack`.
- `clear_ack`  out  1  one-cycle pulse; the flash is done or was aborted.
- `bar_on`  out  1  warning bar enable for the pixel source.
- `bar_color`  out  12  RGB444 colour of the bar.
- `border_color`  out  12  RGB444 colour of the border columns.

## Operation
- States: IDLE, WARN, CLEAR, OVER. State and outputs update only in a cycle where `frame_tick`=1, except `clear_ack`.
- Reset values:
  - state=IDLE, `bar_on`=0, `bar_color`=12'hF00, `border_color`=12'hFFF, `clear_ack`=0.
  - Both counters are 0.
  - A `frame_tick` asserted together with `reset` is ignored.
- Tick priority from IDLE and WARN: `game_over` > `clear_req` > danger (`stack_top_y` ≤ `BAR_Y`, unsigned) > none.
- IDLE, on tick:
  - `game_over` → OVER.
  - else `clear_req` → CLEAR.
  - else danger → WARN.
  - else stay. Outputs: `bar_on`=0, border white.
- WARN:
  - Entry sets `bar_on`=1 and `blink_cnt`=0.
  - Each later tick that stays in WARN: if `blink_cnt`=`BLINK_FRAMES`-1, toggle `bar_on` and clear `blink_cnt`; otherwise increment it.
  - Danger gone at a tick → IDLE with `bar_on`=0.
  - `game_over` or `clear_req` preempt per the priority above.
  - `bar_color`=12'hF00, border white.
- CLEAR:
  - Entry sets `flash_cnt`=0, `border_color`=12'hFF0, `bar_on`=0.
  - Each tick: if `flash_cnt`=`FLASH_FRAMES`-1, set border white, pulse `clear_ack` in the cycle after the tick, and go to IDLE. Otherwise increment `flash_cnt` and toggle the border between 12'hFF0 and 12'hFFF.
  - `game_over` at any tick in CLEAR → OVER (abort). `clear_ack` is still pulsed so the requester is released.
- OVER:
  - `bar_on`=1 solid, `bar_color`=12'hF00, `border_color`=12'hF00.
  - At a tick with `game_over`=0 → IDLE, with all outputs at their reset values.
- Handshake:
  - A request is accepted only at a tick.
  - The requester drops `clear_req` the cycle after `clear_ack`.
  - `clear_req` still high at the next tick starts a new flash.
- Width rules:
  - `blink_cnt` is $clog2(`BLINK_FRAMES`+1) bits.
  - `flash_cnt` is $clog2(`FLASH_FRAMES`+1) bits.
  - Counters never wrap past their terminal values.

## Timing
- Latency: outputs reflect a tick decision on the cycle after `frame_tick` (registered), i.e. inside vertical blanking.
- `clear_ack` is high for exactly one cycle, the cycle after the exiting tick. It is never asserted outside a CLEAR exit.
- CLEAR occupies exactly `FLASH_FRAMES` frames: the ack follows the `FLASH_FRAMES`-th tick after the entry tick.
- WARN phases last `BLINK_FRAMES` frames each, counting the entry frame.
- `reset` mid-CLEAR: return to IDLE with no ack; the requester is reset too.
- Inputs that change between ticks have no effect; only values sampled at a tick matter.

## Test plan
- Reset, then 3 ticks with `stack_top_y`=400, `game_over`=0, `clear_req`=0 → `bar_on`=0, `border_color`=12'hFFF, `bar_color`=12'hF00 throughout.
- `stack_top_y`=181 at a tick, `BLINK_FRAMES`=15 → `bar_on`=1 for 15 frames, 0 for 15, 1 again. `stack_top_y`=182 at a later tick → IDLE, `bar_on`=0.
- `clear_req`=1 held, `FLASH_FRAMES`=8 → border FF0,FFF,… for 8 frames. `clear_ack` is one cycle after the 8th tick, then border FFF. Drop req → stays IDLE.
- `game_over`=1 on the 3rd tick of CLEAR → `clear_ack` pulse, then bar on, bar F00, border F00. `game_over`=0 at a later tick → reset outputs.
- `game_over` and `clear_req` and danger together at a tick from IDLE → OVER; no `clear_ack`.
- `reset` asserted mid-WARN and mid-CLEAR, plus a `frame_tick` coincident with reset → reset values, no ack, tick ignored.
